acc_cache_unit: RTL
===================

Name: acc_cache_unit

Overview:
Parametrised successor to the single-register accumulator. Holds a direct-mapped cache of ENTRIES tape cells addressed by the data pointer, so pointer moves between recently used cells need no memory traffic. Dirty cells are written back and missing cells are filled through a req/ack memory handshake. Sits between the datapath (ALU, source select, pointer unit) and data memory, and drives ready/stall to control.

Parameters:
DATA_W, 8, cell/accumulator width in bits
ADDR_W, 16, data-pointer/memory address width
ENTRIES, 4, cache lines; power of two, >=2; IDX_W = log2(ENTRIES), TAG_W = ADDR_W-IDX_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ptr  in  ADDR_W  current data pointer, sampled every cycle
acc_write  in  CONTROL  write enable for the cell at ptr
acc_src  in  ACC_SRC  write source: 0 -> zero, 1 -> alu_out, 2 -> ext_in, 3 -> constant one
alu_out  in  DATA_W  ALU result
ext_in  in  DATA_W  external input byte
flush  in  1  request write-back of all dirty lines
acc_out  out  DATA_W  cell at ptr; 0 when not ready
acc_zero  out  1  acc_out == 0
acc_ready  out  1  ptr hits and FSM is idle; control stalls while low
flush_done  out  1  one-cycle pulse when a flush completes
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write-back, 0 = fill
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write-back data
mem_rdata  in  DATA_W  fill data, valid with mem_ack
mem_ack  in  1  completes the request in the cycle it is high

Behaviour:
- Line index = ptr[IDX_W-1:0]; tag = ptr[ADDR_W-1:IDX_W]. hit = valid[idx] && tag match, evaluated combinationally.
- Reset: all valid/dirty = 0, state AC_IDLE, mem_req = 0, flush_done = 0, acc_ready = 0. Reset mid-transaction drops mem_req immediately. Dirty data is lost.
- acc_ready = (state == AC_IDLE) && hit && !flush.
- AC_IDLE:
  - flush high -> AC_FLUSH with scan index 0. Flush has priority over miss.
  - Else on miss, latch ptr into miss_addr. Go to AC_WB if the victim line is valid and dirty, else AC_FILL.
- AC_WB: mem_req = 1, mem_we = 1, mem_addr = {victim tag, idx}, mem_wdata = victim data. On ack: dirty = 0, go to AC_FILL.
- AC_FILL: mem_req = 1, mem_we = 0, mem_addr = miss_addr. On ack: line data = mem_rdata, tag from miss_addr, valid = 1, dirty = 0, go to AC_IDLE.
- Request outputs stay stable while mem_req is high. An ack in the first request cycle is legal.
- Miss-to-ready latency with clean victim and immediate ack: 2 cycles (miss cycle, FILL cycle, ready on the next).
- ptr changes during AC_WB or AC_FILL do not disturb the transaction. Hit is re-evaluated in AC_IDLE, so a new miss starts a new sequence.
- Write: acc_write && acc_ready. Line data = selected source (constant one zero-extended to DATA_W), dirty = 1. New value appears on acc_out the next cycle. acc_write while not ready is ignored; control must hold it.
- A write and a ptr change in the same cycle: the write goes to the ptr presented in that cycle.
- AC_FLUSH:
  - Each line at the scan index that is valid and dirty gets a write-back handshake, then dirty = 0 (valid kept). Clean lines take 1 cycle each.
  - After index ENTRIES-1: pulse flush_done, return to AC_IDLE.
  - flush held high re-triggers only after returning to AC_IDLE for one cycle.

Optional Feature:
ACC_CACHE_STATS_EN
- Defined: adds outputs hit_count and miss_count, 32 bits each, saturating, cleared by reset.
  - hit_count increments on each accepted write.
  - miss_count increments on each AC_IDLE -> AC_WB/AC_FILL transition.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package definitions gains:
  - enum ACC_CACHE_STATE {AC_IDLE, AC_WB, AC_FILL, AC_FLUSH}.
  - ACC_SRC encodings as named constants.
  - Existing BYTE/CONTROL types reused.
- Sub-module acc_line_array: data/tag/valid/dirty storage with one read index (ptr), one victim/scan read, one write port, and asynchronous reset of valid/dirty.

Test Plan:
- Reset, ptr=0x0005, ack after 1 cycle -> FILL req addr 0x0005; mem_rdata 0x2A gives acc_ready=1, acc_out=0x2A, acc_zero=0.
- Hit write: acc_src=3, acc_write=1 on 0x0005 -> acc_out=0x01 next cycle; acc_src=0 -> acc_out=0x00, acc_zero=1.
- Conflict: dirty 0x0005=0x07, then ptr=0x0009 (same idx, ENTRIES=4) -> WB addr 0x0005 data 0x07, then FILL addr 0x0009. Back to ptr 0x0005 -> WB 0x0009 (if dirty), FILL 0x0005.
- Ack delayed 5 cycles with ptr changed mid-FILL -> mem_addr/mem_req stable, fill lands in the latched line, then the new ptr is serviced.
- Flush with lines 0 and 2 dirty -> exactly two write-backs in index order, flush_done one cycle. A second flush produces no requests.
- Assert reset during WB -> mem_req low same cycle; after release, acc_ready=0 and all lines invalid.

Source files
------------

// File: rtl/acc_cache_unit_pkg.sv
// rtl/acc_cache_unit_pkg.sv - shared types and encodings for the accumulator cache unit
package acc_cache_unit_pkg;

    typedef logic [7:0] byte_t;
    typedef logic       control_t;
    typedef logic [1:0] acc_src_t;

    localparam acc_src_t ACC_SRC_ZERO = 2'd0;
    localparam acc_src_t ACC_SRC_ALU  = 2'd1;
    localparam acc_src_t ACC_SRC_EXT  = 2'd2;
    localparam acc_src_t ACC_SRC_ONE  = 2'd3;

    localparam logic [1:0] AC_IDLE  = 2'd0;
    localparam logic [1:0] AC_WB    = 2'd1;
    localparam logic [1:0] AC_FILL  = 2'd2;
    localparam logic [1:0] AC_FLUSH = 2'd3;

endpackage

// File: rtl/acc_cache_unit_line_array.sv
// rtl/acc_cache_unit_line_array.sv - direct-mapped line storage: ptr read, victim/scan read, one write port
module acc_line_array #(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 14,
    parameter int IDX_W   = 2,
    parameter int ENTRIES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic [IDX_W-1:0]  vic_idx,
    output logic [DATA_W-1:0] vic_data,
    output logic [TAG_W-1:0]  vic_tag,
    output logic              vic_valid,
    output logic              vic_dirty,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_valid,
    input  logic              wr_dirty
);

    logic [DATA_W-1:0]  data_q [ENTRIES];
    logic [DATA_W-1:0]  data_d [ENTRIES];
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_d  [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] dirty_q, dirty_d;

    assign rd_data   = data_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_valid  = valid_q[rd_idx];
    assign vic_data  = data_q[vic_idx];
    assign vic_tag   = tag_q[vic_idx];
    assign vic_valid = valid_q[vic_idx];
    assign vic_dirty = dirty_q[vic_idx];

    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            data_d[wr_idx]  = wr_data;
            tag_d[wr_idx]   = wr_tag;
            valid_d[wr_idx] = wr_valid;
            dirty_d[wr_idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/acc_cache_unit.sv
// rtl/acc_cache_unit.sv - direct-mapped tape-cell cache with write-back/fill handshake and flush
// Optional statistics counters enabled by defining ACC_CACHE_STATS_EN.
module acc_cache_unit
    import acc_cache_unit_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ptr,
    input  control_t          acc_write,
    input  acc_src_t          acc_src,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] ext_in,
    input  logic              flush,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_zero,
    output logic              acc_ready,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef ACC_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [IDX_W-1:0]  scan_q, scan_d;
    logic              flush_done_q, flush_done_d;

    logic [IDX_W-1:0]  ptr_idx, miss_idx, vic_idx, wr_idx;
    logic [TAG_W-1:0]  ptr_tag, miss_tag, rd_tag, vic_tag, wr_tag;
    logic [DATA_W-1:0] rd_data, vic_data, wr_data, src_val;
    logic              rd_valid, vic_valid, vic_dirty;
    logic              wr_en, wr_valid, wr_dirty, hit, line_done;

    assign ptr_idx  = ptr[IDX_W-1:0];
    assign ptr_tag  = ptr[ADDR_W-1:IDX_W];
    assign miss_idx = miss_addr_q[IDX_W-1:0];
    assign miss_tag = miss_addr_q[ADDR_W-1:IDX_W];

    assign hit        = rd_valid && (rd_tag == ptr_tag);
    assign acc_ready  = (state_q == AC_IDLE) && hit && !flush;
    assign acc_out    = acc_ready ? rd_data : '0;
    assign acc_zero   = (acc_out == '0);
    assign flush_done = flush_done_q;
    assign mem_wdata  = vic_data;

    acc_line_array #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W),
        .ENTRIES (ENTRIES)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (ptr_idx),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .vic_idx   (vic_idx),
        .vic_data  (vic_data),
        .vic_tag   (vic_tag),
        .vic_valid (vic_valid),
        .vic_dirty (vic_dirty),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_tag    (wr_tag),
        .wr_valid  (wr_valid),
        .wr_dirty  (wr_dirty)
    );

    always_comb begin
        case (acc_src)
            ACC_SRC_ZERO: src_val = '0;
            ACC_SRC_ALU:  src_val = alu_out;
            ACC_SRC_EXT:  src_val = ext_in;
            default:      src_val = DATA_W'(1);
        endcase
    end

    // Victim port follows ptr while idle so the miss decision sees the line about to be replaced.
    always_comb begin
        case (state_q)
            AC_IDLE:  vic_idx = ptr_idx;
            AC_FLUSH: vic_idx = scan_q;
            default:  vic_idx = miss_idx;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        scan_d       = scan_q;
        flush_done_d = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = vic_idx;
        wr_data      = vic_data;
        wr_tag       = vic_tag;
        wr_valid     = vic_valid;
        wr_dirty     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = miss_addr_q;
        line_done    = 1'b0;
        case (state_q)
            AC_IDLE: begin
                if (flush) begin
                    state_d = AC_FLUSH;
                    scan_d  = '0;
                end else if (!hit) begin
                    miss_addr_d = ptr;
                    state_d     = (vic_valid && vic_dirty) ? AC_WB : AC_FILL;
                end else if (acc_write) begin
                    wr_en    = 1'b1;
                    wr_idx   = ptr_idx;
                    wr_data  = src_val;
                    wr_tag   = ptr_tag;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b1;
                end
            end
            AC_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {vic_tag, vic_idx};
                if (mem_ack) begin
                    wr_en   = 1'b1;
                    state_d = AC_FILL;
                end
            end
            AC_FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wr_en    = 1'b1;
                    wr_data  = mem_rdata;
                    wr_tag   = miss_tag;
                    wr_valid = 1'b1;
                    state_d  = AC_IDLE;
                end
            end
            default: begin
                if (vic_valid && vic_dirty) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {vic_tag, vic_idx};
                    wr_en     = mem_ack;
                    line_done = mem_ack;
                end else begin
                    line_done = 1'b1;
                end
                if (line_done) begin
                    if (scan_q == IDX_W'(ENTRIES - 1)) begin
                        state_d      = AC_IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        scan_d = scan_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= AC_IDLE;
            miss_addr_q  <= '0;
            scan_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            scan_q       <= scan_d;
            flush_done_q <= flush_done_d;
        end
    end

`ifdef ACC_CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (acc_write && acc_ready && (hit_count_q != '1))
            hit_count_d = hit_count_q + 32'd1;
        if ((state_q == AC_IDLE) && ((state_d == AC_WB) || (state_d == AC_FILL)) && (miss_count_q != '1))
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
